// File: rtl/stage_pingpong_buffer_pkg.sv
// ---------------------------------------------------------------------------
// stage_pingpong_buffer_pkg
// Shared constants for the ping-pong stage buffer: pipeline-wide default
// word and per-bank address widths, and the bank encoding used by the top.
// ---------------------------------------------------------------------------
package stage_pingpong_buffer_pkg;

    localparam int PP_DATA_WIDTH = 8;
    localparam int PP_ADDR_WIDTH = 6;

    // Bank selector encoding: the writer starts in bank 0 after reset.
    localparam logic PP_BANK_RESET = 1'b0;

endpackage : stage_pingpong_buffer_pkg

// File: rtl/stage_pingpong_buffer_ram.sv
// ---------------------------------------------------------------------------
// pingpong_ram
// Simple dual-port RAM holding both banks, addressed as {bank, addr}.
// One write port, one synchronous read port with a registered, enabled
// output. The array itself is never reset so it maps onto block RAM; only
// the output register is cleared.
// Ports:
//   clk, rst          clock, synchronous active-high reset (output reg only)
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr      read port (data appears one cycle after i_re)
//   o_rdata           registered read data, holds when i_re=0
// ---------------------------------------------------------------------------
module pingpong_ram
    import stage_pingpong_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = PP_DATA_WIDTH,
    parameter int ADDR_WIDTH = PP_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH:0]   i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH:0]   i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Write port: contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: registered output, updated only on a read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= {DATA_WIDTH{1'b0}};
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : pingpong_ram

// File: rtl/stage_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// stage_pingpong_buffer
// Double buffer between two pipeline stages. The producer writes the bank
// selected by wr_bank while the consumer reads the other one. A one-cycle
// buffer_switch pulse swaps the banks and hands the written length over as
// rd_count.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   buffer_switch   one-cycle pulse, swaps banks
//   wr_en/wr_addr/wr_data   producer write into the writer bank
//   wr_count        highest written address + 1 since last switch
//   rd_en/rd_addr   consumer read from the reader bank
//   rd_data         registered read data (1-cycle latency)
//   rd_valid        rd_data updated this cycle
//   rd_oob          with rd_valid: read address was >= rd_count
//   rd_count        valid length of the reader bank
//   wr_bank         writer bank; reader owns ~wr_bank
// ---------------------------------------------------------------------------
module stage_pingpong_buffer
    import stage_pingpong_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = PP_DATA_WIDTH,
    parameter int ADDR_WIDTH = PP_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  buffer_switch,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH:0]   wr_count,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_oob,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  wr_bank
);

    logic                r_wr_bank;
    logic [ADDR_WIDTH:0] r_wr_count;
    logic [ADDR_WIDTH:0] r_rd_count;
    logic                r_rd_valid;
    logic                r_rd_oob;

    logic [ADDR_WIDTH:0] w_wr_addr_inc;
    logic [ADDR_WIDTH:0] w_wr_count_next;
    logic                w_rd_oob;

    assign w_wr_addr_inc = {1'b0, wr_addr} + {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Running write length including this cycle's write, so a switch in the
    // same cycle hands over a count that already covers that write.
    always_comb begin
        w_wr_count_next = r_wr_count;
        if (wr_en && (w_wr_addr_inc > r_wr_count)) begin
            w_wr_count_next = w_wr_addr_inc;
        end else begin
            w_wr_count_next = r_wr_count;
        end
    end

    // Out-of-range flag uses the count in force before any switch this edge.
    always_comb begin
        w_rd_oob = 1'b0;
        if (rd_en) begin
            w_rd_oob = ({1'b0, rd_addr} >= r_rd_count);
        end else begin
            w_rd_oob = 1'b0;
        end
    end

    // Bank toggle and length bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank  <= PP_BANK_RESET;
            r_wr_count <= {(ADDR_WIDTH+1){1'b0}};
            r_rd_count <= {(ADDR_WIDTH+1){1'b0}};
        end else if (buffer_switch) begin
            r_wr_bank  <= ~r_wr_bank;
            r_rd_count <= w_wr_count_next;
            r_wr_count <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            r_wr_count <= w_wr_count_next;
        end
    end

    // Read qualifiers aligned with the RAM's registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_oob   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_rd_oob   <= w_rd_oob;
        end
    end

    // Write and read use the pre-edge bank, so a switch-cycle write lands in
    // the bank about to become the reader and a switch-cycle read sees the
    // old reader bank. The two never address the same bank.
    pingpong_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (wr_en),
        .i_waddr ({r_wr_bank, wr_addr}),
        .i_wdata (wr_data),
        .i_re    (rd_en),
        .i_raddr ({~r_wr_bank, rd_addr}),
        .o_rdata (rd_data)
    );

    assign wr_bank  = r_wr_bank;
    assign wr_count = r_wr_count;
    assign rd_count = r_rd_count;
    assign rd_valid = r_rd_valid;
    assign rd_oob   = r_rd_oob;

endmodule : stage_pingpong_buffer
